// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one 128-bit key register and one shared 4-byte S-box slice
// deliver round keys 0..10 in order over a valid/ready handshake.
module aes_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] cipher_key,
    output logic         busy,
    output logic [0:127] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         done
);

    typedef enum logic {
        IDLE,
        GEN
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;
    localparam logic [7:0] RCON_FIRST = 8'h01;

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] pos;
        pos = 11'd2047 - {x, 3'b000};
        return SBOX_TABLE[pos -: 8];
    endfunction

    // Words are held MSB-first: byte 0 of a word sits in bits [31:24].
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    state_t       state, state_next;
    logic [0:127] key_next;
    logic [3:0]   idx_next;
    logic [7:0]   rcon, rcon_next, rcon_dbl;
    logic         done_next;
    logic [31:0]  w0, w1, w2, w3, temp, n0, n1, n2, n3;

    always_comb begin
        w0       = round_key[0:31];
        w1       = round_key[32:63];
        w2       = round_key[64:95];
        w3       = round_key[96:127];
        temp     = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
        n0       = w0 ^ temp;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        rcon_dbl = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        key_next   = round_key;
        idx_next   = round_idx;
        rcon_next  = rcon;
        done_next  = 1'b0;
        busy       = 1'b0;
        key_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    key_next   = cipher_key;
                    idx_next   = 4'd0;
                    rcon_next  = RCON_FIRST;
                    state_next = GEN;
                end
            end
            GEN: begin
                busy      = 1'b1;
                key_valid = 1'b1;
                if (key_ready) begin
                    if (round_idx == LAST_ROUND) begin
                        // Final key stays on the outputs after the schedule closes.
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        key_next  = {n0, n1, n2, n3};
                        idx_next  = round_idx + 4'd1;
                        rcon_next = rcon_dbl;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            round_key <= '0;
            round_idx <= 4'd0;
            rcon      <= RCON_FIRST;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            round_key <= key_next;
            round_idx <= idx_next;
            rcon      <= rcon_next;
            done      <= done_next;
        end
    end

endmodule
